// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: scan controller for a 4:1 mux plus one-hot digit enables.
// Cycles through the slots set in digit_mask, DIV clocks per slot, with the
// enables held off for the first BLANK_CYC clocks of each slot (ghosting gap).
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      async active-low reset (release is re-timed by one clock)
//   en         scan enable; low returns to IDLE
//   digit_mask bit i = 1 -> slot i is scanned
//   hold       freezes counter, state and outputs (ignored in IDLE)
//   sel        mux select {s1,s0}
//   an         one-hot slot enable, polarity per AN_ACTIVE_LOW
//   blank      high when no enable is asserted
//   slot_tick  one-cycle pulse on the last cycle of each slot
module mux_scan_ctrl #(
  parameter int DIV           = 50000,
  parameter int BLANK_CYC     = 64,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] digit_mask,
  input  logic       hold,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic       blank,
  output logic       slot_tick
);

  localparam logic [15:0] CNT_LAST   = 16'(DIV - 1);
  localparam logic [15:0] BLANK_LAST = (BLANK_CYC > 0) ? 16'(BLANK_CYC - 1) : 16'd0;
  localparam bit          NO_BLANK   = (BLANK_CYC == 0);
  localparam logic [3:0]  AN_OFF     = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [1:0]  sel_n;
  logic [3:0]  an_n;
  logic        blank_n, tick_n;
  logic        kill, kill_n;   // current slot lost its mask bit; stay dark to slot end
  logic        run_q;          // low for the first edge after reset release
  logic        show;
  logic        start;          // begin a new slot this edge
  logic [1:0]  start_sel;

  function automatic logic [1:0] lowest_slot(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 3; k >= 0; k--)
      if (m[k]) r = 2'(k);
    return r;
  endfunction

  // Next set bit strictly after cur, wrapping; cur itself if it is the only one.
  function automatic logic [1:0] next_slot(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] r, idx;
    r = cur;
    for (int k = 3; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (m[idx]) r = idx;
    end
    return r;
  endfunction

  function automatic logic [3:0] an_on(input logic [1:0] s);
    logic [3:0] oh;
    oh = 4'b0001 << s;
    return (AN_ACTIVE_LOW != 0) ? ~oh : oh;
  endfunction

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sel_n     = sel;
    kill_n    = kill;
    an_n      = an;
    blank_n   = blank;
    tick_n    = 1'b0;
    show      = 1'b0;
    start     = 1'b0;
    start_sel = 2'd0;

    if (!run_q || !en || digit_mask == 4'b0000) begin
      state_n = IDLE;
      cnt_n   = 16'd0;
      sel_n   = 2'd0;
      kill_n  = 1'b0;
      an_n    = AN_OFF;
      blank_n = 1'b1;
    end else if (state == IDLE) begin
      start     = 1'b1;
      start_sel = lowest_slot(digit_mask);
    end else if (hold) begin
      // everything frozen, tick suppressed
    end else if (cnt == CNT_LAST) begin
      start     = 1'b1;
      start_sel = next_slot(digit_mask, sel);
    end else begin
      cnt_n  = cnt + 16'd1;
      kill_n = kill | ~digit_mask[sel];
      if (state == BLANK && cnt == BLANK_LAST) state_n = SHOW;
      show    = (state_n == SHOW) && !kill_n;
      an_n    = show ? an_on(sel) : AN_OFF;
      blank_n = !show;
      tick_n  = (cnt_n == CNT_LAST);
    end

    // start_sel is always a set mask bit here, so no kill on slot entry
    if (start) begin
      cnt_n  = 16'd0;
      kill_n = 1'b0;
      sel_n  = start_sel;
      if (NO_BLANK) begin
        state_n = SHOW;
        an_n    = an_on(start_sel);
        blank_n = 1'b0;
      end else begin
        state_n = BLANK;
        an_n    = AN_OFF;
        blank_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= 1'b0;
      state     <= IDLE;
      cnt       <= 16'd0;
      kill      <= 1'b0;
      sel       <= 2'd0;
      an        <= AN_OFF;
      blank     <= 1'b1;
      slot_tick <= 1'b0;
    end else begin
      run_q     <= 1'b1;
      state     <= state_n;
      cnt       <= cnt_n;
      kill      <= kill_n;
      sel       <= sel_n;
      an        <= an_n;
      blank     <= blank_n;
      slot_tick <= tick_n;
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with DIV=8, BLANK_CYC=2, active-low enables.
// Observed word per cycle is {sel, an, blank, slot_tick}.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] digit_mask;
  logic       hold;
  logic [1:0] sel;
  logic [3:0] an;
  logic       blank;
  logic       slot_tick;

  int n_chk  = 0;
  int n_pass = 0;

  logic [1:0] seq [8];

  mux_scan_ctrl #(.DIV(8), .BLANK_CYC(2), .AN_ACTIVE_LOW(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digit_mask (digit_mask),
    .hold       (hold),
    .sel        (sel),
    .an         (an),
    .blank      (blank),
    .slot_tick  (slot_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] obs();
    return {sel, an, blank, slot_tick};
  endfunction

  function automatic logic [7:0] pack(input logic [1:0] s, input logic [3:0] a,
                                      input logic b, input logic t);
    return {s, a, b, t};
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starting at cnt=0 of a slot, check nslots full slots following seq[].
  task automatic check_slots(input string tag, input int nslots);
    logic [3:0] oh;
    logic [1:0] s;
    int c;
    for (int k = 0; k < nslots * 8; k++) begin
      s  = seq[k / 8];
      c  = k % 8;
      oh = 4'b0001 << s;
      chk(tag, obs(), pack(s, (c < 2) ? 4'hF : ~oh, c < 2, c == 7));
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; digit_mask = 4'b1111; hold = 1'b0;
    repeat (2) step();
    chk("reset", obs(), pack(2'd0, 4'hF, 1'b1, 1'b0));
    rst_n = 1'b1;
    step();
    chk("release_idle", obs(), pack(2'd0, 4'hF, 1'b1, 1'b0));
    step();

    // full mask round-robin
    seq[0] = 0; seq[1] = 1; seq[2] = 2; seq[3] = 3; seq[4] = 0;
    check_slots("scan_1111", 5);

    // en low -> IDLE, then mask 0101 alternates 0,2
    en = 1'b0;
    step();
    chk("en_off_idle", obs(), pack(2'd0, 4'hF, 1'b1, 1'b0));
    digit_mask = 4'b0101; en = 1'b1;
    step();
    seq[0] = 0; seq[1] = 2; seq[2] = 0; seq[3] = 2;
    check_slots("scan_0101", 4);

    // mask to zero mid-SHOW, then single slot 3
    repeat (3) step();
    chk("pre_zero_show", obs(), pack(2'd0, 4'hE, 1'b0, 1'b0));
    digit_mask = 4'b0000;
    step();
    chk("mask_zero_idle", obs(), pack(2'd0, 4'hF, 1'b1, 1'b0));
    digit_mask = 4'b1000;
    step();
    chk("mask_1000_start", obs(), pack(2'd3, 4'hF, 1'b1, 1'b0));
    digit_mask = 4'b1111;
    seq[0] = 3; seq[1] = 0;
    check_slots("wrap_3_0", 2);

    // hold for 5 cycles at cnt=4 of slot 1
    repeat (4) step();
    chk("hold_pre", obs(), pack(2'd1, 4'hD, 1'b0, 1'b0));
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_frozen", obs(), pack(2'd1, 4'hD, 1'b0, 1'b0));
    end
    hold = 1'b0;
    step(); chk("hold_cnt5", obs(), pack(2'd1, 4'hD, 1'b0, 1'b0));
    step(); chk("hold_cnt6", obs(), pack(2'd1, 4'hD, 1'b0, 1'b0));
    step(); chk("hold_cnt7", obs(), pack(2'd1, 4'hD, 1'b0, 1'b1));
    step(); chk("hold_next", obs(), pack(2'd2, 4'hF, 1'b1, 1'b0));

    // async reset at cnt=5 of slot 2
    repeat (5) step();
    chk("rst_pre", obs(), pack(2'd2, 4'hB, 1'b0, 1'b0));
    #2 rst_n = 1'b0;
    #1 chk("async_reset", obs(), pack(2'd0, 4'hF, 1'b1, 1'b0));
    #2 rst_n = 1'b1;
    step();
    chk("rst_release_idle", obs(), pack(2'd0, 4'hF, 1'b1, 1'b0));
    step();
    seq[0] = 0; seq[1] = 1;
    check_slots("restart", 2);

    // clear slot 2's bit during SHOW
    repeat (3) step();
    chk("kill_pre", obs(), pack(2'd2, 4'hB, 1'b0, 1'b0));
    digit_mask = 4'b1011;
    step(); chk("kill_cnt4", obs(), pack(2'd2, 4'hF, 1'b1, 1'b0));
    step(); chk("kill_cnt5", obs(), pack(2'd2, 4'hF, 1'b1, 1'b0));
    step(); chk("kill_cnt6", obs(), pack(2'd2, 4'hF, 1'b1, 1'b0));
    step(); chk("kill_cnt7", obs(), pack(2'd2, 4'hF, 1'b1, 1'b1));
    step();
    seq[0] = 3; seq[1] = 0; seq[2] = 1; seq[3] = 3;
    check_slots("scan_1011", 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
